// File: rtl/ysyx_24080006_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24080006_mdu_iter
//  Brief    : Iterative RV32M-style multiply/divide unit with its own datapath,
//             radix-2^MUL_STEP multiplier and restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_24080006_mdu_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            signed_a,
    input  logic            signed_b,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int                 c_CNT_W     = $clog2(XLEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_MUL_ITERS = c_CNT_W'(XLEN / MUL_STEP);
    localparam logic [c_CNT_W-1:0] c_DIV_ITERS = c_CNT_W'(XLEN);
    localparam logic [XLEN-1:0]    c_MIN       = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [1:0]         c_OP_MULL   = 2'd0;
    localparam logic [1:0]         c_OP_MULH   = 2'd1;
    localparam logic [1:0]         c_OP_DIV    = 2'd2;
    localparam logic [1:0]         c_OP_REM    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [1:0]            r_op;
    logic                  r_neg;
    logic                  r_special;
    logic [XLEN-1:0]       r_spec_val;
    logic [c_CNT_W-1:0]    r_cnt;
    // MUL: running product. DIV: {partial remainder, dividend/quotient}.
    logic [2*XLEN-1:0]     r_acc;
    // MUL: left-shifting multiplicand. DIV: divisor in the low half.
    logic [2*XLEN-1:0]     r_opb;
    logic [XLEN-1:0]       r_mplier;
    logic [XLEN-1:0]       r_result;
    logic                  r_out_valid;

    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_sa;
    logic                  w_sb;
    logic [XLEN-1:0]       w_abs_a;
    logic [XLEN-1:0]       w_abs_b;
    logic                  w_is_mul;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic                  w_special;
    logic [XLEN-1:0]       w_spec_val;
    logic [2*XLEN-1:0]     w_mul_acc;
    logic [XLEN:0]         w_div_shift;
    logic [XLEN:0]         w_div_diff;
    logic [2*XLEN-1:0]     w_div_acc;
    logic [2*XLEN-1:0]     w_prod_s;
    logic [XLEN-1:0]       w_quo;
    logic [XLEN-1:0]       w_rem;
    logic [XLEN-1:0]       w_final;

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign out_valid = r_out_valid;
    assign result    = r_result;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_xfer   = r_out_valid && out_ready;
    assign w_last   = (r_cnt == c_CNT_ONE);

    assign w_sa     = signed_a && a[XLEN-1];
    assign w_sb     = signed_b && b[XLEN-1];
    assign w_abs_a  = w_sa ? (~a + 1'b1) : a;
    assign w_abs_b  = w_sb ? (~b + 1'b1) : b;
    assign w_is_mul = !op[1];

    assign w_div_zero = (b == '0);
    assign w_ovf      = signed_a && signed_b && (a == c_MIN) && (b == '1);
    assign w_special  = op[1] && (w_div_zero || w_ovf);

    always_comb begin
        w_spec_val = '0;
        if (w_div_zero) begin
            w_spec_val = (op == c_OP_REM) ? a : '1;
        end else begin
            w_spec_val = (op == c_OP_REM) ? '0 : c_MIN;
        end
    end

    // One radix-2^MUL_STEP digit of shift-add per cycle.
    always_comb begin
        w_mul_acc = r_acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (r_mplier[j]) begin
                w_mul_acc = w_mul_acc + (r_opb << j);
            end
        end
    end

    // Restoring step: the top bit of the difference is the borrow.
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb[XLEN-1:0]};

    always_comb begin
        if (!w_div_diff[XLEN]) begin
            w_div_acc = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_div_acc = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end
    end

    assign w_prod_s = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_quo    = r_acc[XLEN-1:0];
    assign w_rem    = r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        if (r_special) begin
            w_final = r_spec_val;
        end else begin
            case (r_op)
                c_OP_MULL: w_final = w_prod_s[XLEN-1:0];
                c_OP_MULH: w_final = w_prod_s[2*XLEN-1:XLEN];
                c_OP_DIV:  w_final = r_neg ? (~w_quo + 1'b1) : w_quo;
                default:   w_final = r_neg ? (~w_rem + 1'b1) : w_rem;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special) begin
                        w_next = S_DONE;
                    end else if (w_is_mul) begin
                        w_next = S_MUL;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                if (w_xfer) begin
                    w_next = S_IDLE;
                end
            end
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    // The first DONE cycle applies the signs and registers the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op        <= '0;
            r_neg       <= 1'b0;
            r_special   <= 1'b0;
            r_spec_val  <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opb       <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_special  <= w_special;
                        r_spec_val <= w_spec_val;
                        r_neg      <= (op == c_OP_REM) ? w_sa : (w_sa ^ w_sb);
                        r_cnt      <= w_is_mul ? c_MUL_ITERS : c_DIV_ITERS;
                        r_acc      <= w_is_mul ? '0 : {{XLEN{1'b0}}, w_abs_a};
                        r_opb      <= w_is_mul ? {{XLEN{1'b0}}, w_abs_a}
                                               : {{XLEN{1'b0}}, w_abs_b};
                        r_mplier   <= w_abs_b;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_mul_acc;
                    r_opb    <= r_opb << MUL_STEP;
                    r_mplier <= r_mplier >> MUL_STEP;
                    r_cnt    <= r_cnt - c_CNT_ONE;
                end
                S_DIV: begin
                    r_acc <= w_div_acc;
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                default: begin
                    if (!r_out_valid && !flush) begin
                        r_result <= w_final;
                    end
                end
            endcase

            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (r_state == S_DONE && !r_out_valid) begin
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24080006_mdu_iter
//  Brief    : Directed vector bench for the iterative multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24080006_mdu_iter;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        signed_a;
    logic        signed_b;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic        sa;
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    ysyx_24080006_mdu_iter #(
        .XLEN     (32),
        .MUL_STEP (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .signed_a  (signed_a),
        .signed_b  (signed_b),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] o, input logic sa, input logic sb,
                             input logic [31:0] va, input logic [31:0] vb);
        in_valid = 1'b1;
        op       = o;
        signed_a = sa;
        signed_b = sb;
        a        = va;
        b        = vb;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int busy_n;
        int ir_high;
        drive_req(v.op, v.sa, v.sb, v.a, v.b);
        tick();
        in_valid = 1'b0;
        lat      = 0;
        busy_n   = busy ? 1 : 0;
        ir_high  = in_ready ? 1 : 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
            if (!out_valid) begin
                busy_n  += busy ? 1 : 0;
                ir_high += in_ready ? 1 : 0;
            end
        end
        check($sformatf("vec%0d result", idx), result, v.exp);
        check($sformatf("vec%0d latency", idx), lat, v.lat);
        check($sformatf("vec%0d busy_cycles", idx), busy_n, v.lat - 1);
        check($sformatf("vec%0d in_ready_while_busy", idx), ir_high, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("vec%0d in_ready_after_xfer", idx), {31'd0, in_ready}, 32'd1);
        check($sformatf("vec%0d out_valid_after_xfer", idx), {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;

        // op: 0=MULL 1=MULH 2=DIV 3=REM
        vecs[0]  = '{2'd0, 1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 17};
        vecs[1]  = '{2'd1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17};
        vecs[2]  = '{2'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17};
        vecs[3]  = '{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 17};
        vecs[4]  = '{2'd2, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{2'd3, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{2'd2, 1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{2'd3, 1'b0, 1'b0, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{2'd2, 1'b1, 1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{2'd3, 1'b1, 1'b1, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{2'd3, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
        vecs[11] = '{2'd2, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[12] = '{2'd3, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[13] = '{2'd2, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[14] = '{2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 17};

        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 2'd0;
        signed_a  = 1'b0;
        signed_b  = 1'b0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: result and out_valid hold while out_ready is low.
        drive_req(2'd0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bp latency", lat, 17);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp hold result %0d", k), result, 32'hFFFF_FFEB);
            check($sformatf("bp hold valid %0d", k), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp in_ready after pulse", {31'd0, in_ready}, 32'd1);

        // Flush ten cycles into a division.
        drive_req(2'd2, 1'b0, 1'b0, 32'd1000, 32'd3);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush div in_ready", {31'd0, in_ready}, 32'd1);
        check("flush div busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            seen += out_valid ? 1 : 0;
        end
        check("flush div no out_valid", seen, 0);

        // Flush wins over a simultaneous request in IDLE.
        drive_req(2'd0, 1'b0, 1'b0, 32'd3, 32'd4);
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush idle busy", {31'd0, busy}, 32'd0);
        check("flush idle in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen += (out_valid || busy) ? 1 : 0;
        end
        check("flush idle nothing started", seen, 0);

        // Flush in DONE discards the pending result.
        drive_req(2'd2, 1'b0, 1'b0, 32'd9, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        check("done valid before flush", {31'd0, out_valid}, 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("done flush out_valid", {31'd0, out_valid}, 32'd0);
        check("done flush in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a multiply clears result too.
        drive_req(2'd0, 1'b0, 1'b0, 32'h1234_5678, 32'd3);
        tick();
        in_valid = 1'b0;
        held = result;
        check("pre-reset result nonzero", {31'd0, held != 32'd0}, 32'd1);
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid reset result", result, 32'd0);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        check("post reset in_ready", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
